// File: rtl/muldiv_peripheral.sv
// Memory-mapped iterative multiply/divide, one bit per cycle; divider present only with `define MULDIV_DIV_EN.
// Results valid WIDTH+2 cycles after START (2 for divide-by-zero); bus accesses stall via wbusy/rbusy while not IDLE.
module muldiv_peripheral #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wstrb,
    input  logic        rstrb,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        wbusy,
    output logic        rbusy,
    output logic [7:0]  LED
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg, mag_b, hi, lo, res_lo, res_hi;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic             op, sgn, neg_a, neg_b, done, dbz, fix_ph;
    logic [CW-1:0]    cnt;
    logic             busy, wr_ok, start, op_in, sgn_in, dbz_start;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_neg;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;
    assign sgn_in = wdata[2];
`ifdef MULDIV_DIV_EN
    assign op_in = wdata[1];
    logic [WIDTH:0] div_rs, div_diff;
    assign div_rs   = {hi, lo[WIDTH-1]};
    assign div_diff = div_rs - {1'b0, mag_b};
`else
    assign op_in = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign wr_ok     = wstrb && !wbusy;
    assign start     = wr_ok && (sel == 3'd2) && wdata[0];
    assign dbz_start = op_in && (b_reg == '0);
    assign a_mag_in  = (sgn_in && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_mag_in  = (sgn_in && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign prod_neg  = -{hi, lo};
    assign LED       = res_lo[7:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dbz_start ? FIX : RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     if (fix_ph) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbusy = wstrb && (sel <= 3'd2) && busy;
        rbusy = rstrb && ((sel == 3'd3) || (sel == 3'd4)) && busy;
        rdata = '0;
        if (rstrb) begin
            case (sel)
                3'd3:    rdata = 32'(res_lo);
                3'd4:    rdata = 32'(res_hi);
                3'd5:    rdata = {29'b0, dbz, done, busy};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            mag_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            res_lo <= '0;
            res_hi <= '0;
            op     <= 1'b0;
            sgn    <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            fix_ph <= 1'b0;
            cnt    <= '0;
        end else begin
            if (wr_ok && sel == 3'd0) a_reg <= wdata[WIDTH-1:0];
            if (wr_ok && sel == 3'd1) b_reg <= wdata[WIDTH-1:0];
            case (state)
                IDLE: if (start) begin
                    op     <= op_in;
                    sgn    <= sgn_in;
                    done   <= 1'b0;
                    dbz    <= 1'b0;
                    cnt    <= '0;
                    fix_ph <= 1'b0;
                    mag_b  <= b_mag_in;
                    // Divide-by-zero preloads its fixed result and skips sign correction.
                    if (dbz_start) begin
                        hi    <= a_reg;
                        lo    <= '1;
                        neg_a <= 1'b0;
                        neg_b <= 1'b0;
                    end else begin
                        hi    <= '0;
                        lo    <= a_mag_in;
                        neg_a <= sgn_in && a_reg[WIDTH-1];
                        neg_b <= sgn_in && b_reg[WIDTH-1];
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
`ifdef MULDIV_DIV_EN
                    if (op) begin
                        if (!div_diff[WIDTH]) begin
                            hi <= div_diff[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= div_rs[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                end
                FIX: begin
                    fix_ph <= ~fix_ph;
                    // First FIX cycle corrects signs in place, second publishes the result.
                    if (!fix_ph) begin
                        if (op) begin
                            if (neg_a ^ neg_b) lo <= -lo;
                            if (neg_a) hi <= -hi;
                        end else if (neg_a ^ neg_b) begin
                            {hi, lo} <= prod_neg;
                        end
                    end else begin
                        res_lo <= lo;
                        res_hi <= hi;
                        done   <= 1'b1;
`ifdef MULDIV_DIV_EN
                        dbz    <= op && (mag_b == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
